// File: rtl/multi_cycle_controller.sv
// multi_cycle_controller: multi-cycle RISC-V style control FSM with a memory-wait
// timeout trap, sticky error reporting and a retired-instruction counter.
module multi_cycle_controller #(
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [6:0]  instr_op_i,
    input  logic        mem_ready_i,
    output logic        PCWrite_o,
    output logic        PCWriteCond_o,
    output logic        IorD_o,
    output logic        IRWrite_o,
    output logic        MemRead_o,
    output logic        MemWrite_o,
    output logic        MemtoReg_o,
    output logic        RegWrite_o,
    output logic        ALUSrcA_o,
    output logic        PCSource_o,
    output logic [1:0]  ALUSrcB_o,
    output logic [1:0]  ALU_op_o,
    output logic [3:0]  state_o,
    output logic        trap_o,
    output logic [1:0]  err_code_o,
    output logic [31:0] instr_cnt_o
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXEC_R   = 4'd6,
        EXEC_I   = 4'd7,
        ALU_WB   = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10
    } state_t;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;
    localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

    state_t      r_state;
    state_t      w_next;
    state_t      w_cur;
    logic [7:0]  r_wait;
    logic        r_trap;
    logic [1:0]  r_err;
    logic [1:0]  w_err_next;
    logic [31:0] r_instr_cnt;
    logic        w_wait_state;
    logic        w_timeout;
    logic        w_retire;
    logic        w_fetch_go;

    assign w_wait_state = (r_state == FETCH) || (r_state == MEM_RD) || (r_state == MEM_WR);
    // ready in the same cycle the counter hits the limit still wins over the timeout
    assign w_timeout = w_wait_state && !mem_ready_i && (r_wait == WAIT_MAX);
    assign w_retire = (w_next == FETCH) &&
                      ((r_state == MEM_WB) || (r_state == MEM_WR) ||
                       (r_state == ALU_WB) || (r_state == BRANCH));

    always_comb begin
        w_next     = r_state;
        w_err_next = 2'b00;
        case (r_state)
            FETCH:    w_next = mem_ready_i ? DECODE : FETCH;
            DECODE: begin
                case (instr_op_i)
                    OP_R:         w_next = EXEC_R;
                    OP_I:         w_next = EXEC_I;
                    OP_LD, OP_ST: w_next = MEM_ADDR;
                    OP_BR:        w_next = BRANCH;
                    default: begin
                        w_next     = TRAP;
                        w_err_next = 2'b01;
                    end
                endcase
            end
            MEM_ADDR: w_next = (instr_op_i == OP_LD) ? MEM_RD : MEM_WR;
            MEM_RD:   w_next = mem_ready_i ? MEM_WB : MEM_RD;
            MEM_WR:   w_next = mem_ready_i ? FETCH : MEM_WR;
            MEM_WB, ALU_WB, BRANCH: w_next = FETCH;
            EXEC_R, EXEC_I:         w_next = ALU_WB;
            TRAP:     w_next = TRAP;
            default: begin
                w_next     = TRAP;
                w_err_next = 2'b01;
            end
        endcase
        if (w_timeout) begin
            w_next     = TRAP;
            w_err_next = 2'b10;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state     <= FETCH;
            r_wait      <= 8'd0;
            r_trap      <= 1'b0;
            r_err       <= 2'b00;
            r_instr_cnt <= 32'd0;
        end else begin
            r_state <= w_next;
            r_wait  <= (w_wait_state && !mem_ready_i) ? r_wait + 8'd1 : 8'd0;
            if (w_next == TRAP && r_state != TRAP) begin
                r_trap <= 1'b1;
                r_err  <= w_err_next;
            end
            if (w_retire)
                r_instr_cnt <= r_instr_cnt + 32'd1;
        end
    end

    // while reset is held the outputs present FETCH, with the ready strobe ignored
    assign w_cur      = rst_i ? r_state : FETCH;
    assign w_fetch_go = rst_i && mem_ready_i;

    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        IorD_o        = 1'b0;
        IRWrite_o     = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        MemtoReg_o    = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        PCSource_o    = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALU_op_o      = 2'b00;
        case (w_cur)
            FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                IRWrite_o = w_fetch_go;
                PCWrite_o = w_fetch_go;
            end
            DECODE:   ALUSrcB_o = 2'b10;
            MEM_ADDR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
            end
            MEM_RD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            MEM_WB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = 1'b1;
            end
            MEM_WR: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
            end
            EXEC_R: begin
                ALUSrcA_o = 1'b1;
                ALU_op_o  = 2'b10;
            end
            EXEC_I: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALU_op_o  = 2'b11;
            end
            ALU_WB:   RegWrite_o = 1'b1;
            BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALU_op_o      = 2'b01;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o     = w_cur;
    assign trap_o      = rst_i && r_trap;
    assign err_code_o  = rst_i ? r_err : 2'b00;
    assign instr_cnt_o = r_instr_cnt;
endmodule

// File: tb/tb_multi_cycle_controller.sv
// tb_multi_cycle_controller: directed and random stimulus checked every cycle
// against a path-queue model of the instruction flow.
module tb_multi_cycle_controller;
    localparam int MAX = 15;
    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        mem_ready_i = 1'b0;
    logic [6:0]  instr_op_i = 7'd0;
    logic        PCWrite_o, PCWriteCond_o, IorD_o, IRWrite_o, MemRead_o, MemWrite_o;
    logic        MemtoReg_o, RegWrite_o, ALUSrcA_o, PCSource_o, trap_o;
    logic [1:0]  ALUSrcB_o, ALU_op_o, err_code_o;
    logic [3:0]  state_o;
    logic [31:0] instr_cnt_o;
    logic [13:0] dut_ctrl;

    multi_cycle_controller #(.MEM_WAIT_MAX(MAX)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .instr_op_i(instr_op_i), .mem_ready_i(mem_ready_i),
        .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .IorD_o(IorD_o),
        .IRWrite_o(IRWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .ALUSrcA_o(ALUSrcA_o),
        .PCSource_o(PCSource_o), .ALUSrcB_o(ALUSrcB_o), .ALU_op_o(ALU_op_o),
        .state_o(state_o), .trap_o(trap_o), .err_code_o(err_code_o), .instr_cnt_o(instr_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegWrite,
    //  ALUSrcA, PCSource, ALUSrcB[1:0], ALU_op[1:0]}
    assign dut_ctrl = {PCWrite_o, PCWriteCond_o, IorD_o, IRWrite_o, MemRead_o, MemWrite_o,
                       MemtoReg_o, RegWrite_o, ALUSrcA_o, PCSource_o, ALUSrcB_o, ALU_op_o};

    int n_tests = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [13:0] ctrl_tab [0:10];
    initial begin
        ctrl_tab[0]  = 14'b0000_1000_00_01_00;
        ctrl_tab[1]  = 14'b0000_0000_00_10_00;
        ctrl_tab[2]  = 14'b0000_0000_10_10_00;
        ctrl_tab[3]  = 14'b0010_1000_00_00_00;
        ctrl_tab[4]  = 14'b0000_0011_00_00_00;
        ctrl_tab[5]  = 14'b0010_0100_00_00_00;
        ctrl_tab[6]  = 14'b0000_0000_10_00_10;
        ctrl_tab[7]  = 14'b0000_0000_10_10_11;
        ctrl_tab[8]  = 14'b0000_0001_00_00_00;
        ctrl_tab[9]  = 14'b0100_0000_11_00_01;
        ctrl_tab[10] = 14'b0000_0000_00_00_00;
    end

    // Model: remaining steps of the current instruction kept in a queue; the
    // memory-facing steps 0, 3 and 5 only advance on ready.
    int          m_state = 0;
    int          m_wait = 0;
    bit          m_trap = 1'b0;
    logic [1:0]  m_err = 2'b00;
    logic [31:0] m_cnt = 32'd0;
    int          m_path[$];

    always @(posedge clk_i) begin
        if (!rst_i) begin
            m_state = 0;
            m_wait = 0;
            m_trap = 1'b0;
            m_err = 2'b00;
            m_cnt = 32'd0;
            m_path.delete();
        end else if (m_state == 10) begin
            m_state = 10;
        end else if ((m_state == 0 || m_state == 3 || m_state == 5) && !mem_ready_i) begin
            if (m_wait == MAX) begin
                m_state = 10;
                m_trap = 1'b1;
                m_err = 2'b10;
            end else
                m_wait++;
        end else begin
            m_wait = 0;
            if (m_state == 0)
                m_path.push_back(1);
            else if (m_state == 1) begin
                if (instr_op_i == OP_R) begin m_path.push_back(6); m_path.push_back(8); end
                else if (instr_op_i == OP_I) begin m_path.push_back(7); m_path.push_back(8); end
                else if (instr_op_i == OP_LD || instr_op_i == OP_ST) m_path.push_back(2);
                else if (instr_op_i == OP_BR) m_path.push_back(9);
                else m_path.push_back(10);
            end else if (m_state == 2) begin
                if (instr_op_i == OP_LD) begin m_path.push_back(3); m_path.push_back(4); end
                else m_path.push_back(5);
            end
            if (m_path.size() == 0) begin
                m_state = 0;
                m_cnt = m_cnt + 32'd1;
            end else begin
                m_state = m_path.pop_front();
                if (m_state == 10) begin
                    m_trap = 1'b1;
                    m_err = 2'b01;
                end
            end
        end
    end

    always @(negedge clk_i) begin : cmp
        int s;
        logic [13:0] e;
        #2;
        s = rst_i ? m_state : 0;
        e = ctrl_tab[s];
        if (s == 0 && rst_i && mem_ready_i)
            e = e | 14'h2400;
        chk("ctrl", 32'(dut_ctrl), 32'(e));
        chk("state", 32'(state_o), 32'(s));
        chk("trap", 32'(trap_o), 32'(rst_i && m_trap));
        chk("err", 32'(err_code_o), rst_i ? 32'(m_err) : 32'd0);
        chk("instr_cnt", instr_cnt_o, m_cnt);
    end

    logic [3:0]  st [64];
    logic [13:0] cv [64];
    logic        tr [64];
    logic [1:0]  ec [64];
    logic [31:0] ic [64];

    task automatic run_seq(input logic [6:0] op, input logic [63:0] rdy, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk_i);
            rst_i = 1'b1;
            instr_op_i = op;
            mem_ready_i = rdy[k];
            #2;
            st[k] = state_o;
            cv[k] = dut_ctrl;
            tr[k] = trap_o;
            ec[k] = err_code_o;
            ic[k] = instr_cnt_o;
        end
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_ready_i = 1'($urandom);
        instr_op_i = 7'($urandom);
    endtask

    task automatic chk_seq(input string name, input logic [127:0] exp, input int n);
        for (int k = 0; k < n; k++)
            chk($sformatf("%s[%0d]", name, k), 32'(st[k]), 32'(exp[4*k +: 4]));
    endtask

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 11))
            0, 1:    return OP_R;
            2, 3:    return OP_I;
            4, 5:    return OP_LD;
            6, 7:    return OP_ST;
            8, 9:    return OP_BR;
            default: return 7'($urandom);
        endcase
    endfunction

    initial begin
        int irw;
        int mode;
        mode = 0;
        // R-type, zero wait
        do_reset();
        run_seq(OP_R, '1, 5);
        chk_seq("rtype_states", 128'h08610, 5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("rtype_regwrite[%0d]", k), 32'(cv[k][6]), (k == 3) ? 32'd1 : 32'd0);
        chk("rtype_cnt", ic[4], 32'd1);
        // load with three stalled MEM_RD cycles
        do_reset();
        run_seq(OP_LD, 64'hC7, 9);
        chk_seq("load_states", 128'h043333210, 9);
        chk("load_memtoreg_wb", 32'(cv[7][7]), 32'd1);
        chk("load_memtoreg_rd", 32'(cv[6][7]), 32'd0);
        // branch
        do_reset();
        run_seq(OP_BR, '1, 4);
        chk_seq("br_states", 128'h0910, 4);
        chk("br_pcwritecond", 32'(cv[2][12]), 32'd1);
        chk("br_pcsource", 32'(cv[2][4]), 32'd1);
        chk("br_aluop", 32'(cv[2][1:0]), 32'd1);
        chk("br_pcwrite", 32'(cv[2][13]), 32'd0);
        chk("br_cond_decode", 32'(cv[1][12]), 32'd0);
        // illegal opcode, trap held, then one reset cycle
        do_reset();
        run_seq(7'b1111111, '1, 23);
        chk_seq("ill_states", 128'hA10, 3);
        chk("ill_trap", 32'(tr[2]), 32'd1);
        chk("ill_err", 32'(ec[2]), 32'd1);
        chk("ill_hold_state", 32'(st[22]), 32'd10);
        chk("ill_hold_err", 32'(ec[22]), 32'd1);
        @(negedge clk_i);
        rst_i = 1'b0;
        mem_ready_i = 1'b1;
        #2;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_irwrite", 32'(IRWrite_o), 32'd0);
        chk("rst_trap", 32'(trap_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        mem_ready_i = 1'b0;
        #2;
        chk("post_rst_state", 32'(state_o), 32'd0);
        chk("post_rst_trap", 32'(trap_o), 32'd0);
        chk("post_rst_err", 32'(err_code_o), 32'd0);
        chk("post_rst_cnt", instr_cnt_o, 32'd0);
        // fetch timeout: counter 0..15 over sixteen FETCH cycles, then TRAP
        do_reset();
        run_seq(OP_R, 64'h0, 18);
        chk("to_state15", 32'(st[15]), 32'd0);
        chk("to_state16", 32'(st[16]), 32'd10);
        chk("to_state17", 32'(st[17]), 32'd10);
        chk("to_err", 32'(ec[16]), 32'd2);
        chk("to_trap", 32'(tr[16]), 32'd1);
        irw = 0;
        for (int k = 0; k < 18; k++)
            irw += int'(cv[k][10]);
        chk("to_irwrite", 32'(irw), 32'd0);
        // ready arriving on the limit cycle still succeeds
        do_reset();
        run_seq(OP_R, 64'h8000, 17);
        chk("edge_state15", 32'(st[15]), 32'd0);
        chk("edge_irwrite", 32'(cv[15][10]), 32'd1);
        chk("edge_state16", 32'(st[16]), 32'd1);
        chk("edge_trap", 32'(tr[16]), 32'd0);
        // MEM_RD timeout
        do_reset();
        run_seq(OP_LD, 64'h7, 20);
        chk("rdto_state18", 32'(st[18]), 32'd3);
        chk("rdto_state19", 32'(st[19]), 32'd10);
        chk("rdto_err", 32'(ec[19]), 32'd2);
        // counter wrap
        do_reset();
        @(negedge clk_i);
        rst_i = 1'b1;
        mem_ready_i = 1'b0;
        instr_op_i = OP_R;
        dut.r_instr_cnt = 32'hFFFF_FFFF;
        m_cnt = 32'hFFFF_FFFF;
        run_seq(OP_R, '1, 5);
        chk("wrap_before", ic[3], 32'hFFFF_FFFF);
        chk("wrap_after", ic[4], 32'd0);
        // random traffic with varying memory latency
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_i);
            if (c % 250 == 0)
                mode = int'($urandom_range(0, 2));
            rst_i = !((m_state == 10 && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0);
            if ($urandom_range(0, 3) == 0)
                instr_op_i = pick_op();
            mem_ready_i = $urandom_range(0, 99) < ((mode == 0) ? 90 : (mode == 1) ? 50 : 4);
        end
        @(negedge clk_i);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
